// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Step counter must hold values 0..a_width-1; sized from a_width+1 so a_width=1 still gets one bit
  function automatic int cnt_width(input int aw);
    return (aw < 1) ? 1 : $clog2(aw + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int b_width = 8
) (
  input  logic [b_width:0]   rem,
  input  logic               q_msb,
  input  logic [b_width-1:0] divisor,
  output logic [b_width:0]   rem_next,
  output logic               q_bit
);

  logic [b_width+1:0] t;
  logic [b_width+1:0] d_ext;

  // Compare at b_width+2 bits so the full partial remainder takes part in the decision
  assign t        = {rem, q_msb};
  assign d_ext    = {2'b00, divisor};
  assign q_bit    = (t >= d_ext);
  assign rem_next = q_bit ? (t[b_width:0] - d_ext[b_width:0]) : t[b_width:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int a_width = 8,
  parameter int b_width = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [a_width+b_width-1:0] dividend,
  input  logic [b_width-1:0]         divisor,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [a_width-1:0]         quotient,
  output logic [b_width-1:0]         remainder,
  output logic                       div_zero,
  output logic                       overflow
);

  localparam int DW = a_width + b_width;
  localparam int CW = cnt_width(a_width);

  div_state_t           state, state_nxt;
  logic [b_width:0]     rem_r;
  logic [a_width-1:0]   q_r;
  logic [b_width-1:0]   dvs_r;
  logic [CW-1:0]        cnt;

  logic [b_width-1:0]   hi;
  logic                 in_fire;
  logic                 last_step;
  logic                 dvs_zero;
  logic                 ovf_hit;
  logic [b_width:0]     rem_nxt;
  logic                 q_bit;
  logic [a_width:0]     q_shift_w;
  logic [a_width-1:0]   q_shift;

  assign hi        = dividend[DW-1:a_width];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign in_fire   = in_valid && in_ready;
  assign last_step = (cnt == CW'(a_width - 1));
  assign dvs_zero  = (divisor == '0);
  // Upper half >= divisor means the quotient needs more than a_width bits
  assign ovf_hit   = (hi >= divisor);
  assign q_shift_w = {q_r, q_bit};
  assign q_shift   = q_shift_w[a_width-1:0];

  div_step #(.b_width(b_width)) u_step (
    .rem      (rem_r),
    .q_msb    (q_r[a_width-1]),
    .divisor  (dvs_r),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_fire) state_nxt = (dvs_zero || ovf_hit) ? DONE : CALC;
      CALC: if (last_step) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r     <= '0;
      q_r       <= '0;
      dvs_r     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_fire) begin
          dvs_r <= divisor;
          cnt   <= '0;
          if (dvs_zero) begin
            div_zero  <= 1'b1;
            quotient  <= '1;
            remainder <= '0;
          end else if (ovf_hit) begin
            overflow  <= 1'b1;
            quotient  <= '1;
            remainder <= '0;
          end else begin
            rem_r <= {1'b0, hi};
            q_r   <= dividend[a_width-1:0];
          end
        end
        CALC: begin
          rem_r <= rem_nxt;
          q_r   <= q_shift;
          cnt   <= cnt + CW'(1);
          // Results are published only on the final step so they stay stable through DONE
          if (last_step) begin
            quotient  <= q_shift;
            remainder <= rem_nxt[b_width-1:0];
          end
        end
        DONE: if (out_ready) begin
          div_zero <= 1'b0;
          overflow <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
